// File: rtl/zx_clock_pkg.sv
// Shared types and decode constants for the 56 MHz clock-enable / reset sequencer.
package zx_clock_pkg;

   // CPU rate selection as seen by the enable decoder.
   typedef enum logic [1:0] {
      T35 = 2'd0,
      T7  = 2'd1,
      T14 = 2'd2
   } turbo_t;

   // Reset sequencer states.
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   // 7 MHz pixel phases, decoded from cnt[2:0].
   localparam logic [2:0] DIV7_P  = 3'd7;
   localparam logic [2:0] DIV7_N  = 3'd3;

   // 3.5 MHz CPU phases, decoded from the full cnt.
   localparam logic [3:0] CPU35_P = 4'd15;
   localparam logic [3:0] CPU35_N = 4'd7;

   // 7 MHz CPU phases, decoded from cnt[2:0].
   localparam logic [2:0] CPU7_P  = 3'd7;
   localparam logic [2:0] CPU7_N  = 3'd3;

   // 14 MHz CPU phases, decoded from cnt[1:0].
   localparam logic [1:0] CPU14_P = 2'd3;
   localparam logic [1:0] CPU14_N = 2'd1;

   // Last divider value of a period; the only point where the CPU rate may change.
   localparam logic [3:0] CNT_LAST = 4'd15;

   // Map the raw 2-bit turbo request onto a rate; 2 and 3 both mean 14 MHz.
   function automatic turbo_t decode_turbo(input logic [1:0] raw);
      case (raw)
         2'd0:    return T35;
         2'd1:    return T7;
         default: return T14;
      endcase
   endfunction

endpackage

// File: rtl/ce_reset_seq_if.sv
// Bundle of the sequencer's lock input, CPU controls and generated enables/reset.
// master: the side providing locked/turbo/stall; slave: the sequencer itself.
interface ce_reset_seq_if;

   logic       locked;
   logic [1:0] turbo;
   logic       stall;
   logic       ce7p;
   logic       ce7n;
   logic       cep;
   logic       cen;
   logic       rst_out;
   logic       ready;

   modport master (
      output locked, turbo, stall,
      input  ce7p, ce7n, cep, cen, rst_out, ready
   );

   modport slave (
      input  locked, turbo, stall,
      output ce7p, ce7n, cep, cen, rst_out, ready
   );

endinterface

// File: rtl/sync_bit.sv
// Generic flop-chain synchronizer for a single asynchronous level.
// Output latency is STAGES clock cycles; chain clears on synchronous reset.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   // Shift the asynchronous level through the chain, oldest sample at the top.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every flop takes its neighbour's old value on the same edge.
      if (reset) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/ce_reset_seq.sv
// Clock-enable and reset sequencer on the 56 MHz system clock.
// Synchronizes the generator lock flag, holds the system in reset for
// RESET_CYCLES after lock, and derives single-cycle 7 MHz pixel and CPU
// enables from a free-running 4-bit divider.
// Build option: define TURBO_EN to honour the turbo port; otherwise the CPU
// runs at 3.5 MHz only.
module ce_reset_seq
   import zx_clock_pkg::*;
#(
   parameter int RESET_CYCLES = 1024,
   parameter int SYNC_STAGES  = 2
) (
   input  logic          clock,
   input  logic          reset,
   ce_reset_seq_if.slave bus
);

   // The lock-seen edge counts as the first hold cycle, so the counter ends at RESET_CYCLES-2.
   localparam int                HOLD_W    = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 2);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [HOLD_W-1:0] r_hold;
   logic              r_ce7p;
   logic              r_ce7n;
   logic              r_cep;
   logic              r_cen;
   logic              r_rst_out;
   logic              r_ready;

   logic   w_lock_s;
   turbo_t w_turbo;
   logic   w_cep_dec;
   logic   w_cen_dec;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clock (clock),
      .reset (reset),
      .i_d   (bus.locked),
      .o_q   (w_lock_s)
   );

`ifdef TURBO_EN
   turbo_t r_turbo;

   // Latch the requested rate only at the end of a divider period so no enable is cut or doubled.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_turbo <= T35;
      end else if (r_cnt == CNT_LAST) begin
         r_turbo <= decode_turbo(bus.turbo);
      end
   end

   assign w_turbo = r_turbo;
`else
   logic w_unused_turbo;

   assign w_unused_turbo = ^bus.turbo;
   assign w_turbo        = T35;
`endif

   // Decode the CPU phases for the current rate; stall drops the pulse outright.
   always_comb begin
      // NOTE: defaults first so every path assigns both decodes and no latch is inferred.
      w_cep_dec = 1'b0;
      w_cen_dec = 1'b0;
      case (w_turbo)
         T35: begin
            w_cep_dec = (r_cnt == CPU35_P);
            w_cen_dec = (r_cnt == CPU35_N);
         end
         T7: begin
            w_cep_dec = (r_cnt[2:0] == CPU7_P);
            w_cen_dec = (r_cnt[2:0] == CPU7_N);
         end
         default: begin
            w_cep_dec = (r_cnt[1:0] == CPU14_P);
            w_cen_dec = (r_cnt[1:0] == CPU14_N);
         end
      endcase
      if (bus.stall) begin
         w_cep_dec = 1'b0;
         w_cen_dec = 1'b0;
      end
   end

   // Reset sequencer, divider and registered enables.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= WAIT_LOCK;
         r_cnt     <= '0;
         r_hold    <= '0;
         r_ce7p    <= 1'b0;
         r_ce7n    <= 1'b0;
         r_cep     <= 1'b0;
         r_cen     <= 1'b0;
         r_rst_out <= 1'b1;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               r_cnt     <= '0;
               r_hold    <= '0;
               r_ce7p    <= 1'b0;
               r_ce7n    <= 1'b0;
               r_cep     <= 1'b0;
               r_cen     <= 1'b0;
               r_rst_out <= 1'b1;
               r_ready   <= 1'b0;
               if (w_lock_s) begin
                  r_state <= HOLD;
               end
            end
            HOLD, RUN: begin
               if (!w_lock_s) begin
                  // Lock lost: fall back and re-run the full hold after relock.
                  r_state   <= WAIT_LOCK;
                  r_cnt     <= '0;
                  r_hold    <= '0;
                  r_ce7p    <= 1'b0;
                  r_ce7n    <= 1'b0;
                  r_cep     <= 1'b0;
                  r_cen     <= 1'b0;
                  r_rst_out <= 1'b1;
                  r_ready   <= 1'b0;
               end else begin
                  r_cnt  <= r_cnt + 4'd1;
                  r_ce7p <= (r_cnt[2:0] == DIV7_P);
                  r_ce7n <= (r_cnt[2:0] == DIV7_N);
                  r_cep  <= w_cep_dec;
                  r_cen  <= w_cen_dec;
                  if (r_state == HOLD) begin
                     if (r_hold == HOLD_LAST) begin
                        r_state   <= RUN;
                        r_rst_out <= 1'b0;
                        r_ready   <= 1'b1;
                     end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                     end
                  end
               end
            end
            default: begin
               r_state <= WAIT_LOCK;
            end
         endcase
      end
   end

   assign bus.ce7p    = r_ce7p;
   assign bus.ce7n    = r_ce7n;
   assign bus.cep     = r_cep;
   assign bus.cen     = r_cen;
   assign bus.rst_out = r_rst_out;
   assign bus.ready   = r_ready;

endmodule
